// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and defaults for the instruction-fetch slice.
//
//   fetch_state_e         BOOT / FETCH / DISCARD sequencing states of fetch_ctrl
//   FETCH_INSTR_BYTES     default PC increment for one sequential fetch
//   FETCH_DATA_WIDTH      default PC / address / instruction width
//   FETCH_RESET_VECTOR    default first fetch address after reset
// -----------------------------------------------------------------------------
package fetch_pkg;

  // BOOT    : one idle cycle after reset while the PC register loads the vector
  // FETCH   : normal operation, requests issued at the current PC
  // DISCARD : a redirect overtook an outstanding request; its response is dropped
  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam int unsigned FETCH_INSTR_BYTES = 4;
  localparam int unsigned FETCH_DATA_WIDTH  = 32;
  localparam logic [FETCH_DATA_WIDTH-1:0] FETCH_RESET_VECTOR = '0;

endpackage

// File: rtl/instr_skid_buf.sv
// -----------------------------------------------------------------------------
// instr_skid_buf
//   One-entry {instruction, pc} holding register between the fetch sequencer and
//   decode. An entry is offered on valid and consumed when valid && ready.
//
//   Priority (highest first): rst, flush, load, accept.
//   - flush drops any held entry (redirect); a load in the same cycle is lost.
//   - load writes a new entry; it may coincide with an accept of the old one,
//     which keeps the buffer full for back-to-back streaming.
//   - instr/pc are only written on load, so they stay stable while valid && !ready
//     and keep their last value after the entry is consumed.
//
// Ports
//   clk        in   1    clock
//   rst        in   1    synchronous active-high reset
//   load       in   1    write {load_instr, load_pc} and set valid
//   flush      in   1    clear valid
//   load_instr in   DW   instruction to store
//   load_pc    in   DW   pc of the instruction to store
//   ready      in   1    consumer accepts when valid && ready
//   valid      out  1    entry present
//   instr      out  DW   stored instruction
//   pc         out  DW   pc of stored instruction
// -----------------------------------------------------------------------------
module instr_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] load_instr,
  input  logic [DATA_WIDTH-1:0] load_pc,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload registers are reset too because the instruction and
      // its pc are visible at the outputs and must read zero after reset.
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Sequences the PC register and instruction-memory fetches. PCNext_o is
//   loaded by an external PC register every cycle and comes back as PC_i.
//   Requests use a req/ack handshake that may complete in the first request
//   cycle; a fetched instruction is buffered for decode in instr_skid_buf.
//
//   A redirect always wins the PCNext mux. When it overtakes a request that has
//   not been acknowledged, the request is not aborted: the sequencer moves to
//   DISCARD, keeps requesting the old address until the ack, and drops that
//   response. The new target is requested in the cycle after that ack.
//
// Ports
//   clk                in   1    clock
//   rst                in   1    synchronous active-high reset
//   PC_i               in   DW   current PC from the PC register
//   PCNext_o           out  DW   next PC, loaded by the PC register every cycle
//   redirect_i         in   1    redirect pulse from execute
//   redirect_target_i  in   DW   redirect destination (bits [1:0] ignored)
//   imem_req_o         out  1    fetch request, held until imem_ack_i
//   imem_addr_o        out  DW   fetch address, stable while imem_req_o
//   imem_ack_i         in   1    fetch complete, imem_rdata_i valid this cycle
//   imem_rdata_i       in   DW   fetched instruction
//   instr_valid_o      out  1    buffered instruction valid toward decode
//   instr_o            out  DW   buffered instruction
//   instr_pc_o         out  DW   pc of buffered instruction
//   decode_ready_i     in   1    decode accepts when instr_valid_o && ready
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = FETCH_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INSTR_BYTES  = FETCH_INSTR_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] PC_i,
  output logic [DATA_WIDTH-1:0] PCNext_o,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_target_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] instr_pc_o,
  input  logic                  decode_ready_i
);

  localparam logic [DATA_WIDTH-1:0] INCR        = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [DATA_WIDTH-1:0] TARGET_MASK = ~(DATA_WIDTH'(3));

  fetch_state_e          state;
  logic [DATA_WIDTH-1:0] hold_addr;   // address of the request being discarded
  logic [DATA_WIDTH-1:0] target;      // word-aligned redirect destination
  logic                  buf_free;    // buffer can take a new entry this cycle
  logic                  fetch_done;  // request acknowledged in FETCH
  logic                  buf_load;

  assign target = redirect_target_i & TARGET_MASK;

  // The entry can be replaced when empty or when decode takes it this cycle,
  // which is what lets a zero-wait memory stream one instruction per cycle.
  assign buf_free = !instr_valid_o || decode_ready_i;

  // ---------------------------------------------------------------------------
  // Request, address and PCNext decisions for the current cycle. These depend
  // on same-cycle ack, ready and redirect, so they are combinational.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    imem_req_o  = 1'b0;
    imem_addr_o = PC_i;
    PCNext_o    = PC_i;
    fetch_done  = 1'b0;
    buf_load    = 1'b0;

    unique case (state)
      BOOT: begin
        // The PC register picks up the vector here, so the first FETCH
        // cycle sees PC_i == RESET_VECTOR.
        PCNext_o = RESET_VECTOR;
      end
      FETCH: begin
        imem_req_o = buf_free;
        fetch_done = buf_free && imem_ack_i;
        if (fetch_done) begin
          PCNext_o = PC_i + INCR;
          buf_load = !redirect_i;
        end
      end
      DISCARD: begin
        // PC_i already holds the redirect target; keep the old request alive.
        imem_req_o  = 1'b1;
        imem_addr_o = hold_addr;
      end
      default: begin
      end
    endcase

    if (redirect_i) begin
      PCNext_o = target;
    end

    // Reset overrides everything, including a request left over in FETCH.
    if (rst) begin
      imem_req_o = 1'b0;
      PCNext_o   = RESET_VECTOR;
      buf_load   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT;
      hold_addr <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          // Any ack seen here belongs to a fetch from before reset: ignored.
          state <= FETCH;
        end
        FETCH: begin
          if (redirect_i && imem_req_o && !imem_ack_i) begin
            state     <= DISCARD;
            hold_addr <= PC_i;
          end
        end
        DISCARD: begin
          // The outstanding request completing ends DISCARD even if another
          // redirect arrives with it; that target is already in PCNext.
          if (imem_ack_i) begin
            state <= FETCH;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side buffer. A redirect flushes it, which also drops any response
  // acknowledged in the same cycle.
  // ---------------------------------------------------------------------------
  instr_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .flush      (redirect_i),
    .load_instr (imem_rdata_i),
    .load_pc    (PC_i),
    .ready      (decode_ready_i),
    .valid      (instr_valid_o),
    .instr      (instr_o),
    .pc         (instr_pc_o)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Drives fetch_ctrl together with a PC register and an IMEM responder with
//   configurable latency. A transaction-level model (flags for boot / stale
//   fetch, a queue for the decode buffer) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int          DW = 32;
  localparam logic [31:0] RV = 32'h0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_reg;
  logic [31:0] pcnext;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        decode_ready = 1'b0;

  always #5 clk = ~clk;

  // PC register paired with the controller.
  always @(posedge clk) pc_reg <= pcnext;

  fetch_ctrl #(
    .DATA_WIDTH   (DW),
    .RESET_VECTOR (RV),
    .INSTR_BYTES  (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .PC_i              (pc_reg),
    .PCNext_o          (pcnext),
    .redirect_i        (redirect),
    .redirect_target_i (redirect_target),
    .imem_req_o        (imem_req),
    .imem_addr_o       (imem_addr),
    .imem_ack_i        (imem_ack),
    .imem_rdata_i      (imem_rdata),
    .instr_valid_o     (instr_valid),
    .instr_o           (instr),
    .instr_pc_o        (instr_pc),
    .decode_ready_i    (decode_ready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_1234;
  endfunction

  // Stimulus knobs
  bit          checks_on   = 1'b0;
  int          ready_pct   = 100;
  int          redir_pct   = 0;
  bit          lat_rand    = 1'b0;
  int          lat_fixed   = 0;
  bit          ack_tied    = 1'b0;
  bit          ack_in_boot = 1'b0;
  bit          force_redir = 1'b0;
  bit          redir_on_ack = 1'b0;
  logic [31:0] force_target = '0;

  // IMEM responder
  bit in_flight = 1'b0;
  int wait_left = 0;

  // Reference model
  bit          m_boot = 1'b0;
  bit          m_stale = 1'b0;
  logic [31:0] m_stale_addr = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_ipc = '0;
  ent_t        m_buf[$];

  // Observations of the last step, for directed checks
  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pcnext, obs_instr, obs_ipc;
  logic [31:0] acc_q[$];
  bit          record_acc = 1'b0;

  task automatic step(input bit do_rst);
    bit          redir;
    logic [31:0] tgt;
    logic [31:0] tgt_al;
    bit          e_req;
    bit          e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_pcn;
    ent_t        e;

    @(negedge clk);
    rst          = do_rst;
    decode_ready = ($urandom_range(0, 99) < ready_pct);
    redir        = !do_rst && ($urandom_range(0, 99) < redir_pct);
    tgt          = $urandom;
    if (force_redir && !do_rst) begin
      redir       = 1'b1;
      tgt         = force_target;
      force_redir = 1'b0;
    end
    redirect        = 1'b0;
    redirect_target = tgt;
    #1;

    // IMEM answers the request it sees on the bus.
    if (do_rst) begin
      imem_ack = 1'b0;
    end else if (ack_tied || (m_boot && ack_in_boot)) begin
      imem_ack = 1'b1;
    end else if (imem_req) begin
      if (!in_flight) begin
        in_flight = 1'b1;
        wait_left = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      end
      imem_ack = (wait_left == 0);
    end else begin
      imem_ack = 1'b0;
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;

    if (redir_on_ack && imem_ack && !do_rst) begin
      redir        = 1'b1;
      tgt          = force_target;
      redir_on_ack = 1'b0;
    end
    redirect        = redir;
    redirect_target = tgt;
    #1;

    // Model expectations for this cycle.
    tgt_al  = tgt & 32'hFFFF_FFFC;
    e_valid = (m_buf.size() != 0);
    e_addr  = m_pc;
    if (do_rst) begin
      e_req = 1'b0;
      e_pcn = RV;
    end else if (m_boot) begin
      e_req = 1'b0;
      e_pcn = redir ? tgt_al : RV;
    end else if (m_stale) begin
      e_req  = 1'b1;
      e_addr = m_stale_addr;
      e_pcn  = redir ? tgt_al : m_pc;
    end else begin
      e_req = !e_valid || decode_ready;
      e_pcn = redir ? tgt_al : ((e_req && imem_ack) ? m_pc + 32'd4 : m_pc);
    end

    obs_req    = imem_req;
    obs_addr   = imem_addr;
    obs_pcnext = pcnext;
    obs_valid  = instr_valid;
    obs_instr  = instr;
    obs_ipc    = instr_pc;
    if (record_acc && instr_valid && decode_ready) acc_q.push_back(instr_pc);

    if (checks_on) begin
      check("req", {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) check("addr", imem_addr, e_addr);
      check("pcnext", pcnext, e_pcn);
      check("valid", {31'd0, instr_valid}, {31'd0, e_valid});
      check("instr", instr, m_instr);
      check("instr_pc", instr_pc, m_ipc);
    end

    // Model update for the clock edge.
    if (do_rst) begin
      m_boot  = 1'b1;
      m_stale = 1'b0;
      m_buf.delete();
      m_instr = '0;
      m_ipc   = '0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_stale) begin
      if (imem_ack) m_stale = 1'b0;
    end else if (redir) begin
      m_buf.delete();
      if (e_req && !imem_ack) begin
        m_stale      = 1'b1;
        m_stale_addr = m_pc;
      end
    end else begin
      if (e_valid && decode_ready) m_buf.delete();
      if (e_req && imem_ack) begin
        e.instr = imem_rdata;
        e.pc    = m_pc;
        m_buf.push_back(e);
        m_instr = imem_rdata;
        m_ipc   = m_pc;
      end
    end
    m_pc = e_pcn;

    // IMEM transaction bookkeeping.
    if (do_rst) begin
      in_flight = 1'b0;
    end else if (!ack_tied) begin
      if (imem_ack) in_flight = 1'b0;
      else if (in_flight) wait_left--;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   v[6];
    bit   found;

    // Initial reset: state is unknown before it, so nothing is compared.
    ack_tied = 1'b1;
    step(1'b1);
    step(1'b1);
    checks_on = 1'b1;

    // 1. Zero-wait IMEM with ack tied high, decode always ready.
    record_acc = 1'b1;
    acc_q.delete();
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      v[i] = obs_valid;
    end
    record_acc = 1'b0;
    ack_tied   = 1'b0;
    check("t1_valid_boot", {31'd0, v[0]}, 32'd0);
    check("t1_valid_fetch", {31'd0, v[1]}, 32'd0);
    check("t1_valid_first", {31'd0, v[2]}, 32'd1);
    check("t1_accepts", acc_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t1_pc_seq", (acc_q.size() > i) ? acc_q[i] : 32'hDEAD_BEEF, 32'(i * 4));
    end

    // 2. Three wait cycles per request.
    lat_fixed = 3;
    for (int i = 0; i < 24; i++) step(1'b0);

    // 3. Decode stalls with the instruction at 0x8 buffered.
    step(1'b1);
    lat_fixed = 0;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0);
      if (m_buf.size() != 0 && m_buf[0].pc == 32'h8) found = 1'b1;
    end
    check("t3_reach", {31'd0, found}, 32'd1);
    ready_pct = 0;
    for (int i = 0; i < 3; i++) step(1'b0);
    check("t3_req_off", {31'd0, obs_req}, 32'd0);
    check("t3_pc_hold", obs_pcnext, 32'hC);
    check("t3_ipc", obs_ipc, 32'h8);
    check("t3_instr", obs_instr, mem_word(32'h8));
    ready_pct = 100;
    step(1'b0);
    check("t3_resume_req", {31'd0, obs_req}, 32'd1);
    check("t3_resume_addr", obs_addr, 32'hC);

    // 4. Redirect while a request waits for its ack.
    step(1'b1);
    lat_fixed = 3;
    step(1'b0);
    step(1'b0);
    force_redir  = 1'b1;
    force_target = 32'h103;
    step(1'b0);
    check("t4_pcnext", obs_pcnext, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0);
      check("t4_old_addr", obs_addr, 32'h0);
      if (!m_stale) found = 1'b1;
    end
    check("t4_discard_done", {31'd0, found}, 32'd1);
    step(1'b0);
    check("t4_new_req", {31'd0, obs_req}, 32'd1);
    check("t4_new_addr", obs_addr, 32'h100);
    check("t4_no_old_valid", {31'd0, obs_valid}, 32'd0);

    // 5. Redirect in the same cycle as the ack.
    step(1'b1);
    lat_fixed = 0;
    step(1'b0);
    redir_on_ack = 1'b1;
    force_target = 32'h200;
    step(1'b0);
    check("t5_pcnext", obs_pcnext, 32'h200);
    step(1'b0);
    check("t5_valid", {31'd0, obs_valid}, 32'd0);
    check("t5_req", {31'd0, obs_req}, 32'd1);
    check("t5_addr", obs_addr, 32'h200);

    // 6. Reset during a wait, stale ack lands in BOOT.
    step(1'b1);
    for (int i = 0; i < 6; i++) step(1'b0);
    lat_fixed = 3;
    step(1'b0);
    step(1'b1);
    ack_in_boot = 1'b1;
    step(1'b0);
    ack_in_boot = 1'b0;
    check("t6_boot_req", {31'd0, obs_req}, 32'd0);
    check("t6_boot_pcnext", obs_pcnext, RV);
    check("t6_boot_valid", {31'd0, obs_valid}, 32'd0);
    check("t6_boot_instr", obs_instr, 32'd0);
    check("t6_boot_ipc", obs_ipc, 32'd0);
    step(1'b0);
    check("t6_first_req", {31'd0, obs_req}, 32'd1);
    check("t6_first_addr", obs_addr, RV);

    // Randomized traffic: latency 0..3, back-pressure, redirects, resets.
    lat_rand  = 1'b1;
    ready_pct = 70;
    redir_pct = 8;
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 99) < 1);
    ready_pct = 25;
    redir_pct = 15;
    for (int i = 0; i < 1500; i++) step($urandom_range(0, 99) < 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
